// File: rtl/seq_adder_pkg.sv
// Shared definitions for the sequential chunked adder: controller states and
// configuration helpers.
package seq_adder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic int num_chunks(input int width, input int chunk);
      return width / chunk;
   endfunction

   function automatic bit chunk_cfg_ok(input int width, input int chunk);
      return (chunk >= 1) && (chunk <= width) && ((width % chunk) == 0);
   endfunction

endpackage

// File: rtl/seq_chunk_adder_chunk.sv
// CHUNK-bit combinational ripple-carry slice, reused once per cycle by the
// sequential adder.
module chunk_adder #(
   parameter int CHUNK = 8
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             cin,
   output logic [CHUNK-1:0] sum,
   output logic             cout
);

   logic c;

   always_comb begin
      sum = '0;
      c   = cin;
      for (int i = 0; i < CHUNK; i++) begin
         sum[i] = a[i] ^ b[i] ^ c;
         c      = (a[i] & b[i]) | (a[i] & c) | (b[i] & c);
      end
      cout = c;
   end

endmodule

// File: rtl/seq_chunk_adder.sv
// Multi-cycle add/subtract: WIDTH bits processed CHUNK bits per clock through
// one shared ripple slice, with start/busy/done handshake and carry/overflow flags.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | waiting for start; results from last operation held
//   RUN   | one chunk added per edge, LSB chunk first
//   DONE  | one cycle; done=1, results valid; start here is accepted
module seq_chunk_adder
   import seq_adder_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int N  = num_chunks(WIDTH, CHUNK);
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   if (!chunk_cfg_ok(WIDTH, CHUNK)) begin : g_bad_cfg
      $error("seq_chunk_adder: WIDTH must be a positive multiple of CHUNK");
   end

   state_t               state, state_nxt;
   logic                 accept;
   logic [WIDTH-1:0]     a_sh, b_sh, part;
   logic                 carry, a_msb, b_msb;
   logic [CW-1:0]        cnt;
   logic [CHUNK-1:0]     slice_sum;
   logic                 slice_cout;
   logic [WIDTH+CHUNK-1:0] part_cat;
   logic [WIDTH-1:0]     part_nxt;

   // Operands shift right each cycle so the slice always sees bits [CHUNK-1:0].
   chunk_adder #(.CHUNK(CHUNK)) u_slice (
      .a    (a_sh[CHUNK-1:0]),
      .b    (b_sh[CHUNK-1:0]),
      .cin  (carry),
      .sum  (slice_sum),
      .cout (slice_cout)
   );

   assign part_cat = {slice_sum, part};
   assign part_nxt = part_cat[WIDTH+CHUNK-1:CHUNK];

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_nxt = RUN;
               accept    = 1'b1;
            end
         end
         RUN: begin
            if (cnt == '0) state_nxt = DONE;
         end
         DONE: begin
            if (start) begin
               state_nxt = RUN;
               accept    = 1'b1;
            end else begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign busy = (state == RUN);
   assign done = (state == DONE);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         a_sh  <= '0;
         b_sh  <= '0;
         part  <= '0;
         carry <= 1'b0;
         a_msb <= 1'b0;
         b_msb <= 1'b0;
         cnt   <= '0;
         sum   <= '0;
         cout  <= 1'b0;
         ovf   <= 1'b0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            a_sh  <= a;
            b_sh  <= sub ? ~b : b;
            carry <= sub ? 1'b1 : cin;
            a_msb <= a[WIDTH-1];
            b_msb <= sub ? ~b[WIDTH-1] : b[WIDTH-1];
            cnt   <= LAST;
            part  <= '0;
         end else if (state == RUN) begin
            a_sh  <= a_sh >> CHUNK;
            b_sh  <= b_sh >> CHUNK;
            carry <= slice_cout;
            part  <= part_nxt;
            cnt   <= cnt - 1'b1;
            if (cnt == '0) begin
               sum  <= part_nxt;
               cout <= slice_cout;
               ovf  <= (a_msb == b_msb) && (slice_sum[CHUNK-1] != a_msb);
            end
         end
      end
   end

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Self-checking bench for seq_chunk_adder: directed handshake/reset scenarios on
// the default configuration plus randomized parameter sweep against an arithmetic model.
module tb_seq_chunk_adder;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // idx 0: 32/8 (directed), 1: 32/1, 2: 32/4, 3: 32/32, 4: 64/16
   logic        start = 0, sub = 0, cin = 0;
   logic [31:0] a = 0, b = 0, sum;
   logic        busy, done, cout, ovf;

   logic        s1_start = 0, s1_sub = 0, s1_cin = 0;
   logic [31:0] s1_a = 0, s1_b = 0, s1_sum;
   logic        s1_busy, s1_done, s1_cout, s1_ovf;
   logic        s2_start = 0, s2_sub = 0, s2_cin = 0;
   logic [31:0] s2_a = 0, s2_b = 0, s2_sum;
   logic        s2_busy, s2_done, s2_cout, s2_ovf;
   logic        s3_start = 0, s3_sub = 0, s3_cin = 0;
   logic [31:0] s3_a = 0, s3_b = 0, s3_sum;
   logic        s3_busy, s3_done, s3_cout, s3_ovf;
   logic        s4_start = 0, s4_sub = 0, s4_cin = 0;
   logic [63:0] s4_a = 0, s4_b = 0, s4_sum;
   logic        s4_busy, s4_done, s4_cout, s4_ovf;

   seq_chunk_adder #(.WIDTH(32), .CHUNK(8)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b), .cin(cin),
      .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf));
   seq_chunk_adder #(.WIDTH(32), .CHUNK(1)) dut_c1 (
      .clk(clk), .rst_n(rst_n), .start(s1_start), .sub(s1_sub), .a(s1_a), .b(s1_b), .cin(s1_cin),
      .busy(s1_busy), .done(s1_done), .sum(s1_sum), .cout(s1_cout), .ovf(s1_ovf));
   seq_chunk_adder #(.WIDTH(32), .CHUNK(4)) dut_c4 (
      .clk(clk), .rst_n(rst_n), .start(s2_start), .sub(s2_sub), .a(s2_a), .b(s2_b), .cin(s2_cin),
      .busy(s2_busy), .done(s2_done), .sum(s2_sum), .cout(s2_cout), .ovf(s2_ovf));
   seq_chunk_adder #(.WIDTH(32), .CHUNK(32)) dut_c32 (
      .clk(clk), .rst_n(rst_n), .start(s3_start), .sub(s3_sub), .a(s3_a), .b(s3_b), .cin(s3_cin),
      .busy(s3_busy), .done(s3_done), .sum(s3_sum), .cout(s3_cout), .ovf(s3_ovf));
   seq_chunk_adder #(.WIDTH(64), .CHUNK(16)) dut_w64 (
      .clk(clk), .rst_n(rst_n), .start(s4_start), .sub(s4_sub), .a(s4_a), .b(s4_b), .cin(s4_cin),
      .busy(s4_busy), .done(s4_done), .sum(s4_sum), .cout(s4_cout), .ovf(s4_ovf));

   int          sel = 0;
   logic        m_busy, m_done, m_cout, m_ovf;
   logic [63:0] m_sum;

   always_comb begin
      m_busy = 1'b0; m_done = 1'b0; m_cout = 1'b0; m_ovf = 1'b0; m_sum = '0;
      case (sel)
         0: begin m_busy = busy;    m_done = done;    m_cout = cout;    m_ovf = ovf;    m_sum = {32'b0, sum};    end
         1: begin m_busy = s1_busy; m_done = s1_done; m_cout = s1_cout; m_ovf = s1_ovf; m_sum = {32'b0, s1_sum}; end
         2: begin m_busy = s2_busy; m_done = s2_done; m_cout = s2_cout; m_ovf = s2_ovf; m_sum = {32'b0, s2_sum}; end
         3: begin m_busy = s3_busy; m_done = s3_done; m_cout = s3_cout; m_ovf = s3_ovf; m_sum = {32'b0, s3_sum}; end
         4: begin m_busy = s4_busy; m_done = s4_done; m_cout = s4_cout; m_ovf = s4_ovf; m_sum = s4_sum;           end
         default: ;
      endcase
   end

   task automatic drive(input int idx, input logic st, input logic [63:0] av, input logic [63:0] bv,
                        input logic sb, input logic ci);
      case (idx)
         0: begin start = st;    a = av[31:0];    b = bv[31:0];    sub = sb;    cin = ci;    end
         1: begin s1_start = st; s1_a = av[31:0]; s1_b = bv[31:0]; s1_sub = sb; s1_cin = ci; end
         2: begin s2_start = st; s2_a = av[31:0]; s2_b = bv[31:0]; s2_sub = sb; s2_cin = ci; end
         3: begin s3_start = st; s3_a = av[31:0]; s3_b = bv[31:0]; s3_sub = sb; s3_cin = ci; end
         4: begin s4_start = st; s4_a = av;       s4_b = bv;       s4_sub = sb; s4_cin = ci; end
         default: ;
      endcase
   endtask

   // Issues one operation from an idle/done cycle; returns at the negedge where done
   // is seen, with lat = number of busy cycles in between.
   task automatic do_op(input int idx, input logic [63:0] av, input logic [63:0] bv,
                        input logic sb, input logic ci, output int lat, output bit to);
      sel = idx;
      @(negedge clk);
      drive(idx, 1'b1, av, bv, sb, ci);
      @(negedge clk);
      drive(idx, 1'b0, av, bv, sb, ci);
      lat = 0;
      to  = 1'b1;
      for (int g = 0; g < 200; g++) begin
         if (m_done) begin
            to = 1'b0;
            break;
         end
         if (m_busy) lat++;
         @(negedge clk);
      end
   endtask

   // Reference: plain wide-integer arithmetic and true signed range test.
   function automatic void ref_op(input int w, input logic [63:0] av, input logic [63:0] bv,
                                  input logic sb, input logic ci,
                                  output logic [63:0] rs, output logic rc, output logic ro);
      logic [63:0]        mask;
      logic [64:0]        full;
      logic [63:0]        bx;
      logic signed [66:0] sa, sbv, tr, one, lim;
      mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
      bx   = sb ? (~bv & mask) : bv;
      full = {1'b0, av} + {1'b0, bx} + ((sb | ci) ? 65'd1 : 65'd0);
      rs   = full[63:0] & mask;
      rc   = full[w];
      one  = 67'sd1;
      sa   = $signed({3'b000, av});
      sbv  = $signed({3'b000, bv});
      if (av[w-1]) sa  = sa  - (one <<< w);
      if (bv[w-1]) sbv = sbv - (one <<< w);
      tr   = sb ? (sa - sbv) : (sa + sbv + (ci ? one : 67'sd0));
      lim  = one <<< (w - 1);
      ro   = (tr > lim - one) || (tr < -lim);
   endfunction

   task automatic test_reset;
      sel = 0;
      rst_n = 1'b0;
      drive(0, 1'b1, 64'h1234, 64'h5678, 1'b0, 1'b1);
      repeat (2) begin
         @(negedge clk);
         checks++;
         if ({busy, done, cout, ovf} !== 4'b0000 || sum !== 32'h0) begin
            errors++;
            $display("FAIL reset_state: busy=%b done=%b sum=%h cout=%b ovf=%b expected all 0",
                     busy, done, sum, cout, ovf);
         end
      end
      drive(0, 1'b0, 64'h0, 64'h0, 1'b0, 1'b0);
      rst_n = 1'b1;
      repeat (2) begin
         @(negedge clk);
         checks++;
         if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_start: busy=%b done=%b expected 0 0", busy, done);
         end
      end
   endtask

   task automatic directed(input string nm, input logic [31:0] av, input logic [31:0] bv,
                           input logic sb, input logic ci,
                           input logic [31:0] es, input logic ec, input logic eo);
      int lat; bit to;
      do_op(0, {32'b0, av}, {32'b0, bv}, sb, ci, lat, to);
      checks++;
      if (to || lat != 4) begin
         errors++;
         $display("FAIL %s_latency: got %0d timeout=%0d expected 4", nm, lat, to);
      end
      checks++;
      if (sum !== es || cout !== ec || ovf !== eo) begin
         errors++;
         $display("FAIL %s_result: got sum=%h cout=%b ovf=%b expected sum=%h cout=%b ovf=%b",
                  nm, sum, cout, ovf, es, ec, eo);
      end
   endtask

   task automatic test_add;
      directed("add_wrap", 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
      directed("add_ovf",  32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
      directed("add_cin",  32'h0000_00FF, 32'h0000_0100, 1'b0, 1'b1, 32'h0000_0200, 1'b0, 1'b0);
   endtask

   task automatic test_sub;
      directed("sub_ovf",    32'h8000_0000, 32'h1, 1'b1, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1);
      directed("sub_borrow", 32'h3, 32'h5, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
   endtask

   task automatic test_back_to_back;
      int nb;
      sel = 0;
      @(negedge clk);
      drive(0, 1'b1, 64'h10, 64'h20, 1'b0, 1'b0);
      @(negedge clk);
      drive(0, 1'b1, 64'hAAAA_0000, 64'h1234, 1'b1, 1'b0);
      nb = 0;
      for (int g = 0; g < 50 && !done; g++) begin
         if (busy) nb++;
         @(negedge clk);
      end
      checks++;
      if (!done || nb != 4 || sum !== 32'h30) begin
         errors++;
         $display("FAIL ignore_start_in_run: done=%b busy_cycles=%0d sum=%h expected 1 4 00000030",
                  done, nb, sum);
      end
      drive(0, 1'b1, 64'd5, 64'd7, 1'b0, 1'b0);
      @(negedge clk);
      drive(0, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0);
      checks++;
      if (busy !== 1'b1 || sum !== 32'h30) begin
         errors++;
         $display("FAIL start_in_done: busy=%b sum=%h expected 1 00000030", busy, sum);
      end
      nb = 0;
      for (int g = 0; g < 50 && !done; g++) begin
         if (busy) nb++;
         if (!done && sum !== 32'h30) begin
            checks++;
            errors++;
            $display("FAIL sum_hold: got %h expected 00000030", sum);
         end
         @(negedge clk);
      end
      checks++;
      if (!done || nb != 4 || sum !== 32'hC || cout !== 1'b0) begin
         errors++;
         $display("FAIL back_to_back: done=%b busy_cycles=%0d sum=%h cout=%b expected 1 4 0000000c 0",
                  done, nb, sum, cout);
      end
   endtask

   task automatic test_reset_mid;
      bit seen; int lat; bit to;
      sel = 0;
      @(negedge clk);
      drive(0, 1'b1, 64'hFFFF_FFFF, 64'h1, 1'b0, 1'b0);
      @(negedge clk);
      drive(0, 1'b0, 64'h0, 64'h0, 1'b0, 1'b0);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      checks++;
      if ({busy, done, cout, ovf} !== 4'b0000 || sum !== 32'h0) begin
         errors++;
         $display("FAIL reset_mid: busy=%b done=%b sum=%h cout=%b ovf=%b expected all 0",
                  busy, done, sum, cout, ovf);
      end
      rst_n = 1'b1;
      seen = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if (done || busy) seen = 1'b1;
      end
      checks++;
      if (seen) begin
         errors++;
         $display("FAIL reset_mid_abort: activity seen=%0d expected 0", seen);
      end
      do_op(0, 64'd100, 64'd23, 1'b0, 1'b0, lat, to);
      checks++;
      if (to || lat != 4 || sum !== 32'd123) begin
         errors++;
         $display("FAIL reset_mid_recover: lat=%0d timeout=%0d sum=%h expected 4 0 0000007b",
                  lat, to, sum);
      end
   endtask

   task automatic test_sweep(input int idx, input int w, input int n, input int ops);
      logic [63:0] mask, av, bv, es;
      logic        sb, ci, ec, eo;
      int          lat;
      bit          to;
      mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
      for (int i = 0; i < ops; i++) begin
         av = {$urandom, $urandom} & mask;
         bv = {$urandom, $urandom} & mask;
         sb = 1'($urandom_range(0, 1));
         ci = 1'($urandom_range(0, 1));
         if (i == 0) begin av = mask; bv = 64'd1; sb = 1'b0; ci = 1'b0; end
         if (i == 1) begin av = 64'd1 << (w - 1); bv = 64'd1; sb = 1'b1; end
         if (i == 2) begin av = mask >> 1; bv = 64'd0; sb = 1'b0; ci = 1'b1; end
         do_op(idx, av, bv, sb, ci, lat, to);
         ref_op(w, av, bv, sb, ci, es, ec, eo);
         checks++;
         if (to || lat != n) begin
            errors++;
            $display("FAIL sweep%0d_latency: got %0d timeout=%0d expected %0d", idx, lat, to, n);
         end
         checks++;
         if (m_sum !== es || m_cout !== ec || m_ovf !== eo) begin
            errors++;
            $display("FAIL sweep%0d_result a=%h b=%h sub=%b cin=%b: got %h/%b/%b expected %h/%b/%b",
                     idx, av, bv, sb, ci, m_sum, m_cout, m_ovf, es, ec, eo);
         end
      end
   endtask

   initial begin
      test_reset();
      test_add();
      test_sub();
      test_back_to_back();
      test_reset_mid();
      test_sweep(0, 32, 4, 200);
      test_sweep(1, 32, 32, 1000);
      test_sweep(2, 32, 8, 1000);
      test_sweep(3, 32, 1, 1000);
      test_sweep(4, 64, 4, 1000);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
